op_integrator: RTL

CIC integrator section of the delta-sigma decimation filter, sitting directly upstream of the comb (differentiator) stage. It accepts the 1-bit modulator stream and runs three cascaded wrap-around accumulators at the modulator rate. On each `lr_clk` rising edge it hands the third integrator's value to the comb stage, which decimates to the audio rate.

---
 rtl/op_integrator.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/op_integrator.sv
// ----------------------------------------------------------------------------
// op_integrator
// Integrator half of a CIC delta-sigma decimator. Three cascaded wrap-around
// accumulators run at the modulator bit rate. On every frame-clock rising edge
// the third accumulator is handed to the downstream comb stage.
//
// Ports
//   clk        in   1      system clock, all logic on its rising edge
//   rst_n      in   1      asynchronous active-low reset
//   mod_clk    in   1      modulator bit clock (synchronous to clk); sample on rise
//   din        in   1      modulator bit: 1 -> +1, 0 -> -1
//   lr_clk     in   1      frame clock (synchronous to clk); capture on rise
//   out        out  WIDTH  captured third-integrator value, held between frames
//   out_valid  out  1      one-cycle pulse in the cycle after out is updated
// ----------------------------------------------------------------------------
module op_integrator #(
    parameter int WIDTH         = 24,
    parameter int SETTLE_FRAMES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mod_clk,
    input  logic             din,
    input  logic             lr_clk,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    localparam int CNT_W = (SETTLE_FRAMES < 2) ? 1 : $clog2(SETTLE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((SETTLE_FRAMES > 0) ? (SETTLE_FRAMES - 1) : 0);
    // With no warm-up frames requested the very first capture is live.
    localparam logic NO_SETTLE = (SETTLE_FRAMES == 0) ? 1'b1 : 1'b0;

    typedef enum logic [0:0] {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } state_e;

    // Map a modulator bit to a sign-extended +1 / -1 step.
    function automatic logic [WIDTH-1:0] bit_to_step(input logic b);
        logic [WIDTH-1:0] step;
        if (b) begin
            step = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            step = {WIDTH{1'b1}};
        end
        return step;
    endfunction

    logic             mod_prev_q, mod_prev_d;
    logic             lr_prev_q,  lr_prev_d;
    logic [WIDTH-1:0] int1_q, int1_d;
    logic [WIDTH-1:0] int2_q, int2_d;
    logic [WIDTH-1:0] int3_q, int3_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    state_e           state_q, state_d;

    logic             mod_ce_s;
    logic             lr_edge_s;
    logic             settled_s;
    logic [WIDTH-1:0] x_s;

    // Edge detection and input mapping.
    always_comb begin
        mod_ce_s   = mod_clk & ~mod_prev_q;
        lr_edge_s  = lr_clk & ~lr_prev_q;
        settled_s  = (state_q == ST_RUN) | NO_SETTLE;
        x_s        = bit_to_step(din);
        mod_prev_d = mod_clk;
        lr_prev_d  = lr_clk;
    end

    // Integrator pipeline: each stage adds the previous-cycle value of the stage
    // before it, so a new sample reaches int3 on the third mod_ce. Wrap is
    // intentional; the comb stage cancels it.
    always_comb begin
        int1_d = int1_q;
        int2_d = int2_q;
        int3_d = int3_q;
        if (mod_ce_s) begin
            int1_d = int1_q + x_s;
            int2_d = int2_q + int1_q;
            int3_d = int3_q + int2_q;
        end else begin
            int1_d = int1_q;
            int2_d = int2_q;
            int3_d = int3_q;
        end
    end

    // Output capture uses the pre-update int3, so a coincident mod_ce is neither
    // lost nor double-counted.
    always_comb begin
        out_d       = out_q;
        out_valid_d = lr_edge_s;
        if (lr_edge_s) begin
            if (settled_s) begin
                out_d = int3_q;
            end else begin
                out_d = {WIDTH{1'b0}};
            end
        end else begin
            out_d = out_q;
        end
    end

    // Settle FSM: stay in warm-up until the last warm-up frame edge; that edge
    // still captures zero because settled_s reflects the current state.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_WARMUP: begin
                if (lr_edge_s) begin
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    if (frame_cnt_q == CNT_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_WARMUP;
                    end
                end else begin
                    state_d = ST_WARMUP;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d     = ST_WARMUP;
                frame_cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mod_prev_q  <= 1'b0;
            lr_prev_q   <= 1'b0;
            int1_q      <= {WIDTH{1'b0}};
            int2_q      <= {WIDTH{1'b0}};
            int3_q      <= {WIDTH{1'b0}};
            out_q       <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            frame_cnt_q <= {CNT_W{1'b0}};
            state_q     <= ST_WARMUP;
        end else begin
            mod_prev_q  <= mod_prev_d;
            lr_prev_q   <= lr_prev_d;
            int1_q      <= int1_d;
            int2_q      <= int2_d;
            int3_q      <= int3_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            frame_cnt_q <= frame_cnt_d;
            state_q     <= state_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule
